// File: rtl/prod_accum_pkg.sv
// prod_accum_pkg
//   Shared definitions for the product accumulator and its neighbours.
//   The default product width lives here so the multiplier (z_opt) and the
//   accumulator always agree on PW.
//   Contents:
//     PW_DEF / AW_DEF / CW_DEF : default product, accumulator and run-counter widths
//     state_t                  : accumulator FSM state encoding

package prod_accum_pkg;

    localparam int PW_DEF = 16;
    localparam int AW_DEF = 24;
    localparam int CW_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/prod_accum_sat_adder.sv
// sat_adder
//   Adds a zero-extended unsigned PW-bit operand to an AW-bit accumulator.
//   With SAT=0 the result wraps modulo 2^AW. With SAT=1 any carry-out clamps
//   the result to all-ones. An all-ones accumulator therefore stays all-ones
//   for the rest of the run, since every further add either carries or adds zero.
//   Ports:
//     acc_in  input  AW  current accumulator value
//     opd_in  input  PW  unsigned operand (never sign-extended)
//     sum_out output AW  wrapped or saturated sum
//     carry   output 1   carry-out of the AW+1-bit add (overflow indication)

module sat_adder #(
    parameter int PW  = 16,
    parameter int AW  = 24,
    parameter bit SAT = 1'b0
) (
    input  logic [AW-1:0] acc_in,
    input  logic [PW-1:0] opd_in,
    output logic [AW-1:0] sum_out,
    output logic          carry
);

    logic [AW:0] sum_wide;

    // The extra top bit of the AW+1-bit sum is the overflow carry.
    always_comb begin
        sum_wide = {1'b0, acc_in} + {{(AW + 1 - PW){1'b0}}, opd_in};
        carry    = sum_wide[AW];
        if (SAT && sum_wide[AW]) begin
            sum_out = '1;
        end else begin
            sum_out = sum_wide[AW-1:0];
        end
    end

endmodule

// File: rtl/prod_accum.sv
// prod_accum
//   Sums a programmed-length run of unsigned products into a wide accumulator.
//   The upstream multiplier raises prod_vld only when its output has settled,
//   so bubbles of any length between products are tolerated.
//   Ports:
//     clk      input  1   clock, all state updates on the rising edge
//     clr_     input  1   synchronous active-high reset, overrides everything
//     start    input  1   begin a new run (honoured only in IDLE)
//     len      input  CW  products in the run, sampled with an accepted start
//     prod_in  input  PW  unsigned product
//     prod_vld input  1   prod_in valid this cycle
//     busy     output 1   high while accumulating
//     acc_out  output AW  registered accumulated sum
//     acc_vld  output 1   one-cycle pulse when acc_out is final
//     ovf      output 1   sticky overflow flag for the current run
//     cnt_out  output CW  products accepted so far in the run

module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int PW  = PW_DEF,
    parameter int AW  = AW_DEF,
    parameter int CW  = CW_DEF,
    parameter bit SAT = 1'b0
) (
    input  logic          clk,
    input  logic          clr_,
    input  logic          start,
    input  logic [CW-1:0] len,
    input  logic [PW-1:0] prod_in,
    input  logic          prod_vld,
    output logic          busy,
    output logic [AW-1:0] acc_out,
    output logic          acc_vld,
    output logic          ovf,
    output logic [CW-1:0] cnt_out
);

    state_t        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          ovf_q, ovf_d;

    logic [AW-1:0] add_sum;
    logic          add_carry;

    sat_adder #(
        .PW  (PW),
        .AW  (AW),
        .SAT (SAT)
    ) u_sat_adder (
        .acc_in  (acc_q),
        .opd_in  (prod_in),
        .sum_out (add_sum),
        .carry   (add_carry)
    );

    always_ff @(posedge clk) begin
        if (clr_) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

    // Results are held after DONE until the next accepted start, so the
    // datapath only changes on an accepted start or an accepted product.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    cnt_d = '0;
                    if (len != '0) begin
                        rem_d   = len;
                        state_d = ST_ACC;
                    end else begin
                        // An empty run still produces a result pulse of zero.
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ACC: begin
                if (prod_vld) begin
                    acc_d = add_sum;
                    if (add_carry) begin
                        ovf_d = 1'b1;
                    end
                    cnt_d = cnt_q + CW'(1);
                    rem_d = rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy    = (state_q == ST_ACC);
    assign acc_vld = (state_q == ST_DONE);
    assign acc_out = acc_q;
    assign ovf     = ovf_q;
    assign cnt_out = cnt_q;

endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum
//   Directed checks of prod_accum. The main instance uses the default widths.
//   Two extra 17-bit instances (wrapping and saturating) share the same
//   stimulus and are examined only in the overflow sequence.

module tb_prod_accum;
    import prod_accum_pkg::*;

    localparam int PW = 16;
    localparam int AW = 24;
    localparam int CW = 4;
    localparam int AWS = 17;

    logic          clk;
    logic          clr_;
    logic          start;
    logic [CW-1:0] len;
    logic [PW-1:0] prod_in;
    logic          prod_vld;

    logic          busy;
    logic [AW-1:0] acc_out;
    logic          acc_vld;
    logic          ovf;
    logic [CW-1:0] cnt_out;

    logic           busy_w, acc_vld_w, ovf_w;
    logic [AWS-1:0] acc_out_w;
    logic [CW-1:0]  cnt_out_w;
    logic           busy_s, acc_vld_s, ovf_s;
    logic [AWS-1:0] acc_out_s;
    logic [CW-1:0]  cnt_out_s;

    int vec_count;
    int miss_count;

    prod_accum #(.PW(PW), .AW(AW), .CW(CW), .SAT(1'b0)) dut (
        .clk(clk), .clr_(clr_), .start(start), .len(len),
        .prod_in(prod_in), .prod_vld(prod_vld),
        .busy(busy), .acc_out(acc_out), .acc_vld(acc_vld),
        .ovf(ovf), .cnt_out(cnt_out)
    );

    prod_accum #(.PW(PW), .AW(AWS), .CW(CW), .SAT(1'b0)) dut_wrap (
        .clk(clk), .clr_(clr_), .start(start), .len(len),
        .prod_in(prod_in), .prod_vld(prod_vld),
        .busy(busy_w), .acc_out(acc_out_w), .acc_vld(acc_vld_w),
        .ovf(ovf_w), .cnt_out(cnt_out_w)
    );

    prod_accum #(.PW(PW), .AW(AWS), .CW(CW), .SAT(1'b1)) dut_sat (
        .clk(clk), .clr_(clr_), .start(start), .len(len),
        .prod_in(prod_in), .prod_vld(prod_vld),
        .busy(busy_s), .acc_out(acc_out_s), .acc_vld(acc_vld_s),
        .ovf(ovf_s), .cnt_out(cnt_out_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          start;
        logic [CW-1:0] len;
        logic          vld;
        logic [PW-1:0] prod;
        logic          exp_busy;
        logic          exp_acc_vld;
        int            exp_acc;
        int            exp_cnt;
        logic          exp_ovf;
    } vector_t;

    vector_t vecs[$];

    // One comparison: counts it, reports a FAIL line on disagreement.
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Advance one clock edge; outputs are looked at 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [CW-1:0] l,
                                 input logic v, input logic [PW-1:0] p);
        start    = s;
        len      = l;
        prod_vld = v;
        prod_in  = p;
        tick();
    endtask

    task automatic checkAll(input string tag, input logic eb, input logic ev,
                            input int ea, input int ec, input logic eo);
        checkOutput({tag, ".busy"},    longint'(busy),    longint'(eb));
        checkOutput({tag, ".acc_vld"}, longint'(acc_vld), longint'(ev));
        checkOutput({tag, ".acc_out"}, longint'(acc_out), longint'(ea));
        checkOutput({tag, ".cnt_out"}, longint'(cnt_out), longint'(ec));
        checkOutput({tag, ".ovf"},     longint'(ovf),     longint'(eo));
    endtask

    task automatic addVec(input string n, input logic s, input int l, input logic v,
                          input int p, input logic eb, input logic ev,
                          input int ea, input int ec, input logic eo);
        vector_t t;
        t.name = n; t.start = s; t.len = CW'(l); t.vld = v; t.prod = PW'(p);
        t.exp_busy = eb; t.exp_acc_vld = ev; t.exp_acc = ea; t.exp_cnt = ec; t.exp_ovf = eo;
        vecs.push_back(t);
    endtask

    initial begin
        vec_count  = 0;
        miss_count = 0;
        clr_     = 1'b1;
        start    = 1'b0;
        len      = '0;
        prod_in  = '0;
        prod_vld = 1'b0;

        // Basic run of three back-to-back products.
        addVec("basic_start", 1, 3, 0, 0,     1, 0, 0,     0, 0);
        addVec("basic_p1",    0, 0, 1, 6,     1, 0, 6,     1, 0);
        addVec("basic_p2",    0, 0, 1, 20,    1, 0, 26,    2, 0);
        addVec("basic_p3",    0, 0, 1, 65025, 0, 1, 65051, 3, 0);
        addVec("basic_hold",  0, 0, 0, 0,     0, 0, 65051, 3, 0);
        // Bubbles between products carry junk that must be ignored.
        addVec("bub_start",   1, 2, 0, 0,     1, 0, 0,     0, 0);
        addVec("bub_p1",      0, 0, 1, 100,   1, 0, 100,   1, 0);
        addVec("bub_gap1",    0, 0, 0, 9999,  1, 0, 100,   1, 0);
        addVec("bub_gap2",    0, 0, 0, 9999,  1, 0, 100,   1, 0);
        addVec("bub_p2",      0, 0, 1, 200,   0, 1, 300,   2, 0);
        addVec("bub_hold",    0, 0, 0, 0,     0, 0, 300,   2, 0);
        // start while accumulating or in DONE is dropped; prod_vld in DONE/IDLE too.
        addVec("ign_start",   1, 2, 0, 0,     1, 0, 0,     0, 0);
        addVec("ign_acc1",    1, 7, 1, 10,    1, 0, 10,    1, 0);
        addVec("ign_acc2",    1, 7, 1, 20,    0, 1, 30,    2, 0);
        addVec("ign_done",    1, 5, 1, 50,    0, 0, 30,    2, 0);
        addVec("ign_idle",    0, 0, 1, 7,     0, 0, 30,    2, 0);
        // Zero-length run goes straight to DONE.
        addVec("zero_start",  1, 0, 0, 0,     0, 1, 0,     0, 0);
        addVec("zero_after",  0, 0, 0, 0,     0, 0, 0,     0, 0);

        // Reset held for two cycles with random activity on the other inputs.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'($urandom), CW'($urandom), 1'($urandom), PW'($urandom));
            checkAll($sformatf("reset%0d", i), 0, 0, 0, 0, 0);
        end
        clr_ = 1'b0;
        applyStimulus(0, 0, 0, 0);

        // Reset in the middle of a 5-product run discards the partial sum.
        applyStimulus(1, 5, 0, 0);
        applyStimulus(0, 0, 1, 1000);
        applyStimulus(0, 0, 1, 2000);
        checkOutput("midrun.acc_before", longint'(acc_out), 3000);
        clr_ = 1'b1;
        applyStimulus(0, 0, 1, 3000);
        checkAll("midrun_clr", 0, 0, 0, 0, 0);
        clr_ = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 4000);
            checkAll($sformatf("midrun_idle%0d", i), 0, 0, 0, 0, 0);
        end

        // Table-driven vectors.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].start, vecs[i].len, vecs[i].vld, vecs[i].prod);
            checkAll(vecs[i].name, vecs[i].exp_busy, vecs[i].exp_acc_vld,
                     vecs[i].exp_acc, vecs[i].exp_cnt, vecs[i].exp_ovf);
        end

        // Overflow at 17 bits: 3 * 65025 = 195075 -> wraps to 64003 or clamps to 131071.
        applyStimulus(1, 3, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 65025);
        checkOutput("ovf_wrap.acc_vld", longint'(acc_vld_w), 1);
        checkOutput("ovf_wrap.acc_out", longint'(acc_out_w), 64003);
        checkOutput("ovf_wrap.ovf",     longint'(ovf_w),     1);
        checkOutput("ovf_sat.acc_vld",  longint'(acc_vld_s), 1);
        checkOutput("ovf_sat.acc_out",  longint'(acc_out_s), 131071);
        checkOutput("ovf_sat.ovf",      longint'(ovf_s),     1);
        checkAll("ovf_wide", 0, 1, 195075, 3, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("ovf_sat.hold_ovf", longint'(ovf_s), 1);
        // Next run clears the sticky flag.
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 0, 1, 5);
        checkOutput("ovf_next_wrap.acc_out", longint'(acc_out_w), 5);
        checkOutput("ovf_next_wrap.ovf",     longint'(ovf_w),     0);
        checkOutput("ovf_next_sat.acc_out",  longint'(acc_out_s), 5);
        checkOutput("ovf_next_sat.ovf",      longint'(ovf_s),     0);
        checkOutput("ovf_next_sat.acc_vld",  longint'(acc_vld_s), 1);
        applyStimulus(0, 0, 0, 0);

        // Maximum run length: 15 * 65025 = 975375.
        applyStimulus(1, 15, 0, 0);
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(0, 0, 1, 65025);
            if (i < 15) begin
                checkAll($sformatf("max_p%0d", i), 1, 0, i * 65025, i, 0);
            end
        end
        checkAll("max_done", 0, 1, 975375, 15, 0);
        applyStimulus(0, 0, 1, 65025);
        checkAll("max_after", 0, 0, 975375, 15, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
